// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one combinational-read data memory between the
// MEM-stage CPU port and a word-wide debug/loader port. The CPU port gets
// byte-lane steering for stores and extraction plus extension for loads.
// The debug port waits for a free slot, or forces one after STARVE_LIMIT
// consecutive CPU grants.
//
// Optional feature macro: DMEM_ARB_PERF_EN adds the saturating performance
// counters perf_stall_cnt and perf_dbg_cnt. With it undefined, those ports
// and counters do not exist.
//
// arb_state and starve_count expose the debug FSM state and the starvation
// counter. They are observation outputs only.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  // CPU (MEM stage) port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_width,
  input  logic              cpu_sign_ext,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              err_misaligned,
  // Debug/loader port
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_ack,
  // Memory side
  output logic              mem_en,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
`ifdef DMEM_ARB_PERF_EN
  output logic [15:0]       perf_stall_cnt,
  output logic [15:0]       perf_dbg_cnt,
`endif
  // Observation
  output logic [1:0]        arb_state,
  output logic [3:0]        starve_count
);

  // Debug handshake: the master raises dbg_req and holds it, together with
  // dbg_we/dbg_addr/dbg_wdata, until it sees the one-cycle dbg_ack pulse.
  // dbg_rdata is valid from the ack cycle onward. The master then drops
  // dbg_req. A new request is accepted only after dbg_req has been seen low
  // in HOLD. A reset in the middle of a transaction aborts it without an ack.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_HOLD = 2'd3
  } dbg_state_t;

  dbg_state_t state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       misaligned;
  logic       cpu_valid;
  logic       dbg_grant;
  logic       cpu_grant;
  logic [3:0] st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // The low address bits of the debug port are ignored by definition.
  logic unused_dbg_lsbs;
  assign unused_dbg_lsbs = ^dbg_addr[1:0];

  // Flag half accesses on odd addresses, word accesses not word aligned,
  // and the reserved width encoding.
  always_comb begin
    misaligned = 1'b0;
    case (cpu_width)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = cpu_addr[0];
      2'b10:   misaligned = |cpu_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // A misaligned CPU access never competes for the memory slot.
  assign cpu_valid = cpu_req & ~misaligned;
  assign dbg_grant = (state == S_WAIT) &&
                     (!cpu_valid || (starve_cnt == 4'(STARVE_LIMIT)));
  assign cpu_grant = cpu_valid & ~dbg_grant;
  assign cpu_stall = dbg_grant & cpu_valid;
  assign dbg_ack   = (state == S_ACK);

  assign arb_state    = state;
  assign starve_count = starve_cnt;

  // Store lane steering: replicate the data and enable only the target lanes.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = cpu_wdata;
    case (cpu_width)
      2'b00: begin
        st_be    = 4'b0001 << cpu_addr[1:0];
        st_wdata = {4{cpu_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = cpu_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{cpu_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = cpu_wdata;
      end
    endcase
  end

  // Load extraction: pick the addressed byte/half and then extend it.
  always_comb begin
    ld_byte   = mem_rdata[7:0];
    ld_half   = cpu_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    cpu_rdata = mem_rdata;
    case (cpu_addr[1:0])
      2'b00:   ld_byte = mem_rdata[7:0];
      2'b01:   ld_byte = mem_rdata[15:8];
      2'b10:   ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    if (misaligned) begin
      cpu_rdata = 32'd0;
    end else if (cpu_width == 2'b00) begin
      cpu_rdata = cpu_sign_ext ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
    end else if (cpu_width == 2'b01) begin
      cpu_rdata = cpu_sign_ext ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
    end
  end

  // Memory-side mux: debug grant, then CPU grant, otherwise no access.
  always_comb begin
    mem_en    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = cpu_addr[ADDR_W-1:2];
    mem_wdata = st_wdata;
    if (dbg_grant) begin
      mem_en    = 1'b1;
      mem_be    = dbg_we ? 4'b1111 : 4'b0000;
      mem_addr  = dbg_addr[ADDR_W-1:2];
      mem_wdata = dbg_wdata;
    end else if (cpu_grant) begin
      mem_en = 1'b1;
      mem_be = cpu_we ? st_be : 4'b0000;
    end
  end

  // Debug FSM next state, and the starvation counter, which counts CPU wins
  // only while debug is waiting.
  always_comb begin
    state_nxt  = state;
    starve_nxt = 4'd0;
    case (state)
      S_IDLE:  if (dbg_req) state_nxt = S_WAIT;
      S_WAIT:  if (dbg_grant) state_nxt = S_ACK;
      S_ACK:   state_nxt = S_HOLD;
      S_HOLD:  if (!dbg_req) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if ((state == S_WAIT) && cpu_grant) begin
      starve_nxt = starve_cnt + 4'd1;
    end
  end

  // State register, debug read capture, and the misalignment error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      starve_cnt     <= 4'd0;
      dbg_rdata      <= 32'd0;
      err_misaligned <= 1'b0;
    end else begin
      state          <= state_nxt;
      starve_cnt     <= starve_nxt;
      err_misaligned <= cpu_req & misaligned;
      if (dbg_grant) begin
        dbg_rdata <= mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_PERF_EN
  // Saturating counts of stall cycles and debug grants.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= 16'd0;
      perf_dbg_cnt   <= 16'd0;
    end else begin
      if (cpu_stall && (perf_stall_cnt != 16'hFFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      end
      if (dbg_grant && (perf_dbg_cnt != 16'hFFFF)) begin
        perf_dbg_cnt <= perf_dbg_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
